qtree_cfg_loader: RTL and testbench
===================================

# qtree_cfg_loader

Configuration loader upstream of `qtree_top`'s stage RAM control interface. Accepts a stream of tree-node records `{stage, addr, l, m, r}` (the same records the bench reads from the `tree` file) over a valid/ready handshake and turns each one into a single-cycle write to the addressed stage RAM. Optionally reads the word back to verify it, flagging mismatches and out-of-range stages. Signals `busy_o` so the lookup path can be held off while the tree is being (re)loaded.

## Interface
- `STAGES`, 4: number of tree stages; valid stage indices are 0..STAGES-1.
- `A_WIDTH`, 8: stage RAM address width.
- `D_WIDTH`, 16: width of each of the l/m/r fields.
- `RD_LAT`, 2: stage RAM read latency in cycles, ≥1.
- `VERIFY`, 1: 1 = read back and compare after every write; 0 = write only.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cfg_valid_i` in 1: record valid.
- `cfg_ready_o` out 1: loader can accept a record.
- `cfg_stage_i` in 8: target stage index.
- `cfg_addr_i` in A_WIDTH: RAM address.
- `cfg_data_i` in 3*D_WIDTH: `{l, m, r}`, with l in the MSBs.
- `cfg_last_i` in 1: last record of this load.
- `wr_en_o` out STAGES: one-hot write strobe.
- `rd_en_o` out STAGES: one-hot read strobe.
- `ram_addr_o` out A_WIDTH: shared write/read address.
- `ram_wdata_o` out 3*D_WIDTH: write data.
- `ram_rdata_i` in STAGES*3*D_WIDTH: read data of all stages, stage 0 in the LSBs.
- `busy_o` out 1: a load is in progress.
- `done_o` out 1: one-cycle pulse when the `last` record completes.
- `mismatch_o` out 1: sticky; a read-back compare failed.
- `bad_stage_o` out 1: sticky; a record had stage ≥ STAGES.
- `err_addr_o` out 8+A_WIDTH: `{stage, addr}` of the first error.
- `wr_cnt_o` out 16: records written since reset, saturating at 0xFFFF.

## Operation
- Registered FSM with states IDLE, WR, RD, WAIT, CHK.
- `cfg_ready_o` = 1 only in IDLE and not in reset.
- **IDLE**
  - On `cfg_valid_i & cfg_ready_o`, latch stage, addr, data and last.
  - Stage < STAGES: go to WR.
  - Stage ≥ STAGES: drop the record. Stay in IDLE, set `bad_stage_o` next cycle, capture `err_addr_o` if this is the first error. If last is set, pulse `done_o` the next cycle.
- **WR** (1 cycle): `wr_en_o[stage]`=1, `ram_addr_o`/`ram_wdata_o` driven from the latched record. `wr_cnt_o` increments. Next state is RD if VERIFY, else IDLE.
- **RD** (1 cycle): `rd_en_o[stage]`=1, same address. Next state is WAIT, or CHK if RD_LAT=1.
- **WAIT**: hold for RD_LAT-1 cycles using a down-counter, then go to CHK.
- **CHK** (1 cycle)
  - Compare `ram_rdata_i[stage*3*D_WIDTH +: 3*D_WIDTH]` with the latched data.
  - On inequality, set `mismatch_o` and capture `err_addr_o` if this is the first error.
  - Return to IDLE.
- **Completion of a record** is the transition to IDLE (from WR when VERIFY=0, from CHK when VERIFY=1). If the record was last, `done_o`=1 in the following cycle.
- **busy_o**: set on acceptance of any record while `busy_o`=0; cleared in the same cycle `done_o` pulses.
- Sticky flags and `err_addr_o` clear only on reset. First error wins; later errors leave `err_addr_o` unchanged.
- At most one of `wr_en_o` and `rd_en_o` is ever nonzero; each is one-hot or zero.

## Timing
- **Reset values**
  - `cfg_ready_o`=1 after reset deassertion; 0 while `rst_i`=1.
  - All other outputs are 0; state is IDLE.
- **Accept at cycle t:** `wr_en_o` at t+1.
  - VERIFY=1: `rd_en_o` at t+2; compare at t+2+RD_LAT; ready again at t+3+RD_LAT.
  - VERIFY=0: ready again at t+2.
- **Throughput:** one record per 3+RD_LAT cycles (VERIFY=1) or per 2 cycles (VERIFY=0).
- Record fields are don't-care while `cfg_ready_o`=0. Upstream holds `cfg_valid_i` and the record until accepted.
- `done_o` occurs one cycle after the completion transition.
- **Reset mid-operation:** asynchronous return to IDLE.
  - Strobes drop immediately.
  - The in-flight record is lost and not counted if WR had not yet occurred.

## Test plan
- **Basic write:** VERIFY=1, RD_LAT=2, model RAM returns written data. Send stage 1, addr 0x05, {l,m,r}={0x0010,0x0020,0x0030}, last=1 at t0.
  - `wr_en_o`=4'b0010 at t1 with addr 0x05 and data 0x001000200030.
  - `rd_en_o`=4'b0010 at t2.
  - `done_o` at t5.
  - `mismatch_o`=0, `wr_cnt_o`=1, `busy_o` low after t5.
- **Back-to-back stream:** 8 records with `cfg_valid_i` held high, VERIFY=0.
  - Exactly one `wr_en_o` every 2 cycles.
  - `wr_cnt_o`=8, single `done_o` after the 8th.
- **Read-back mismatch:** model RAM corrupts stage 2, addr 0x7F, bit 0 of r.
  - `mismatch_o`=1, `err_addr_o`={8'd2,8'h7F}.
  - A later mismatch at stage 3 leaves `err_addr_o` unchanged.
- **Bad stage:** stage=4 with STAGES=4, last=1.
  - No `wr_en_o`/`rd_en_o`.
  - `bad_stage_o`=1 and `done_o` the next cycle; `cfg_ready_o` stays high.
- **Reset during WAIT:** assert `rst_i` mid-WAIT.
  - All outputs 0 immediately; `cfg_ready_o`=1 after release.
  - `wr_cnt_o`=0; the next record loads normally.
- **Counter saturation:** force 65,536 writes.
  - `wr_cnt_o` holds at 0xFFFF.

Source files
------------

// File: rtl/qtree_cfg_loader.sv
// Configuration loader for the qtree stage RAMs: turns a stream of {stage, addr, l, m, r}
// records into single-cycle RAM writes, with optional read-back verification.
module qtree_cfg_loader #(
  parameter int STAGES  = 4,
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 16,
  parameter int RD_LAT  = 2,
  parameter bit VERIFY  = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [7:0]                    cfg_stage_i,
  input  logic [A_WIDTH-1:0]            cfg_addr_i,
  input  logic [3*D_WIDTH-1:0]          cfg_data_i,
  input  logic                          cfg_last_i,
  output logic [STAGES-1:0]             wr_en_o,
  output logic [STAGES-1:0]             rd_en_o,
  output logic [A_WIDTH-1:0]            ram_addr_o,
  output logic [3*D_WIDTH-1:0]          ram_wdata_o,
  input  logic [STAGES*3*D_WIDTH-1:0]   ram_rdata_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          mismatch_o,
  output logic                          bad_stage_o,
  output logic [8+A_WIDTH-1:0]          err_addr_o,
  output logic [15:0]                   wr_cnt_o
);

  localparam int         WW       = 3 * D_WIDTH;
  localparam int         WCW      = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [7:0] STAGES_W = 8'(STAGES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_WAIT,
    S_CHK
  } state_t;

  state_t               r_state;
  logic [7:0]           r_stage;
  logic [A_WIDTH-1:0]   r_addr;
  logic [WW-1:0]        r_data;
  logic                 r_last;
  logic [STAGES-1:0]    r_wr_en;
  logic [STAGES-1:0]    r_rd_en;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_mismatch;
  logic                 r_bad_stage;
  logic [8+A_WIDTH-1:0] r_err_addr;
  logic [15:0]          r_wr_cnt;
  logic [WCW-1:0]       r_wait_cnt;

  logic                 w_accept;
  logic                 w_stage_ok;
  logic                 w_err_seen;
  logic [WW-1:0]        w_rd_word;
  logic                 w_cmp_fail;

  function automatic logic [STAGES-1:0] f_onehot(input logic [7:0] stage);
    logic [STAGES-1:0] oh;
    oh = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (stage == 8'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  assign cfg_ready_o = (r_state == S_IDLE) && !rst_i;
  assign w_accept    = cfg_valid_i && cfg_ready_o;
  assign w_stage_ok  = cfg_stage_i < STAGES_W;
  assign w_err_seen  = r_mismatch || r_bad_stage;

  // Select the addressed stage's read word; r_stage is always in range once latched past IDLE.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (r_stage == 8'(i)) w_rd_word = ram_rdata_i[i*WW +: WW];
    end
  end

  assign w_cmp_fail = (w_rd_word != r_data);

  // NOTE: all state and outputs are updated with non-blocking assignments so every
  // branch below reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_stage     <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_wr_en     <= '0;
      r_rd_en     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mismatch  <= 1'b0;
      r_bad_stage <= 1'b0;
      r_err_addr  <= '0;
      r_wr_cnt    <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_stage <= cfg_stage_i;
            r_addr  <= cfg_addr_i;
            r_data  <= cfg_data_i;
            r_last  <= cfg_last_i;
            if (w_stage_ok) begin
              r_wr_en <= f_onehot(cfg_stage_i);
              r_busy  <= 1'b1;
              r_state <= S_WR;
            end else begin
              // Dropped record still completes a load if it was the last one.
              r_bad_stage <= 1'b1;
              if (!w_err_seen) r_err_addr <= {cfg_stage_i, cfg_addr_i};
              r_done <= cfg_last_i;
              r_busy <= !cfg_last_i;
            end
          end
        end

        S_WR: begin
          r_wr_en <= '0;
          if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
          if (VERIFY) begin
            r_rd_en <= f_onehot(r_stage);
            r_state <= S_RD;
          end else begin
            r_done  <= r_last;
            if (r_last) r_busy <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_RD: begin
          r_rd_en <= '0;
          if (RD_LAT == 1) begin
            r_state <= S_CHK;
          end else begin
            r_wait_cnt <= WCW'(RD_LAT - 2);
            r_state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (r_wait_cnt == '0) r_state <= S_CHK;
          else                  r_wait_cnt <= r_wait_cnt - 1'b1;
        end

        S_CHK: begin
          if (w_cmp_fail) begin
            r_mismatch <= 1'b1;
            if (!w_err_seen) r_err_addr <= {r_stage, r_addr};
          end
          r_done  <= r_last;
          if (r_last) r_busy <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_en_o     = r_wr_en;
  assign rd_en_o     = r_rd_en;
  assign ram_addr_o  = r_addr;
  assign ram_wdata_o = r_data;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign mismatch_o  = r_mismatch;
  assign bad_stage_o = r_bad_stage;
  assign err_addr_o  = r_err_addr;
  assign wr_cnt_o    = r_wr_cnt;

endmodule

// File: tb/tb_qtree_cfg_loader.sv
// Bench for qtree_cfg_loader: one verifying instance and one write-only instance,
// each with a behavioural stage RAM and a write scoreboard.
module tb_qtree_cfg_loader;

  localparam int ST = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int WW = 3 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0: VERIFY=1 instance, index 1: VERIFY=0 instance.
  logic              cfg_valid [2];
  logic              cfg_ready [2];
  logic [7:0]        cfg_stage [2];
  logic [AW-1:0]     cfg_addr  [2];
  logic [WW-1:0]     cfg_data  [2];
  logic              cfg_last  [2];
  logic [ST-1:0]     wr_en     [2];
  logic [ST-1:0]     rd_en     [2];
  logic [AW-1:0]     ram_addr  [2];
  logic [WW-1:0]     ram_wdata [2];
  logic [ST*WW-1:0]  ram_rdata [2];
  logic              busy      [2];
  logic              done      [2];
  logic              mismatch  [2];
  logic              bad_stage [2];
  logic [8+AW-1:0]   err_addr  [2];
  logic [15:0]       wr_cnt    [2];

  qtree_cfg_loader #(.STAGES(ST), .A_WIDTH(AW), .D_WIDTH(DW), .RD_LAT(RL), .VERIFY(1'b1)) u_dut_v (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid[0]), .cfg_ready_o(cfg_ready[0]), .cfg_stage_i(cfg_stage[0]),
    .cfg_addr_i(cfg_addr[0]), .cfg_data_i(cfg_data[0]), .cfg_last_i(cfg_last[0]),
    .wr_en_o(wr_en[0]), .rd_en_o(rd_en[0]), .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]),
    .ram_rdata_i(ram_rdata[0]), .busy_o(busy[0]), .done_o(done[0]), .mismatch_o(mismatch[0]),
    .bad_stage_o(bad_stage[0]), .err_addr_o(err_addr[0]), .wr_cnt_o(wr_cnt[0])
  );

  qtree_cfg_loader #(.STAGES(ST), .A_WIDTH(AW), .D_WIDTH(DW), .RD_LAT(RL), .VERIFY(1'b0)) u_dut_w (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid[1]), .cfg_ready_o(cfg_ready[1]), .cfg_stage_i(cfg_stage[1]),
    .cfg_addr_i(cfg_addr[1]), .cfg_data_i(cfg_data[1]), .cfg_last_i(cfg_last[1]),
    .wr_en_o(wr_en[1]), .rd_en_o(rd_en[1]), .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]),
    .ram_rdata_i(ram_rdata[1]), .busy_o(busy[1]), .done_o(done[1]), .mismatch_o(mismatch[1]),
    .bad_stage_o(bad_stage[1]), .err_addr_o(err_addr[1]), .wr_cnt_o(wr_cnt[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  // Behavioural stage RAMs with an RL-deep read pipeline; two locations read back corrupted.
  logic [WW-1:0] mem    [2][ST][256];
  logic [WW-1:0] pipe_d [2][RL];
  logic [7:0]    pipe_s [2][RL];

  function automatic logic [WW-1:0] corrupt(input int s, input logic [7:0] a);
    return ((s == 2 && a == 8'h7F) || (s == 3 && a == 8'h33)) ? WW'(1) : WW'(0);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < ST; s++) begin
        if (wr_en[k][s]) mem[k][s][ram_addr[k]] <= ram_wdata[k];
        if (rd_en[k][s]) begin
          pipe_d[k][0] <= mem[k][s][ram_addr[k]] ^ corrupt(s, ram_addr[k]);
          pipe_s[k][0] <= 8'(s);
        end
      end
      for (int j = 1; j < RL; j++) begin
        pipe_d[k][j] <= pipe_d[k][j-1];
        pipe_s[k][j] <= pipe_s[k][j-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ram_rdata[k] = '0;
      for (int s = 0; s < ST; s++) begin
        if (pipe_s[k][RL-1] == 8'(s)) ram_rdata[k][s*WW +: WW] = pipe_d[k][RL-1];
      end
    end
  end

  // Scoreboard: expected {onehot, addr, data} pushed on acceptance, popped on each write strobe.
  logic [63:0] exp_q0 [$];
  logic [63:0] exp_q1 [$];
  logic [63:0] mon_got, mon_exp;
  logic [ST-1:0] last_oh   [2];
  logic [AW-1:0] last_addr [2];
  int  cyc = 0;
  int  prev_wr  [2];
  int  done_cnt [2];
  bit  stream_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (done[k]) done_cnt[k]++;
        if (wr_en[k] != '0) begin
          mon_got = 64'({wr_en[k], ram_addr[k], ram_wdata[k]});
          mon_exp = '0;
          if (k == 0 && exp_q0.size() > 0) mon_exp = exp_q0.pop_front();
          if (k == 1 && exp_q1.size() > 0) mon_exp = exp_q1.pop_front();
          check($sformatf("write%0d", k), mon_got, mon_exp);
          if (k == 1 && stream_mode && prev_wr[1] >= 0)
            check("write_gap", 64'(cyc - prev_wr[1]), 64'd2);
          prev_wr[k]   = cyc;
          last_oh[k]   = wr_en[k];
          last_addr[k] = ram_addr[k];
        end
        if (rd_en[k] != '0)
          check($sformatf("read%0d", k), 64'({rd_en[k], ram_addr[k], 8'(cyc - prev_wr[k])}),
                64'({(k == 0) ? last_oh[k] : 4'h0, last_addr[k], 8'd1}));
      end
    end
  end

  task automatic send(input int k, input logic [7:0] s, input logic [7:0] a,
                      input logic [WW-1:0] d, input logic l);
    int n;
    logic [ST-1:0] oh;
    n = 0;
    cfg_valid[k] = 1'b1;
    cfg_stage[k] = s;
    cfg_addr[k]  = a;
    cfg_data[k]  = d;
    cfg_last[k]  = l;
    while (!cfg_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready[k]) begin
      check("send_timeout", 64'(cfg_ready[k]), 64'd1);
    end else if (s < 8'(ST)) begin
      oh = 4'b0001 << s[1:0];
      if (k == 0) exp_q0.push_back(64'({oh, a, d}));
      else        exp_q1.push_back(64'({oh, a, d}));
    end
    @(negedge clk);
    cfg_valid[k] = 1'b0;
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (!cfg_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready[k]) check("ready_timeout", 64'(cfg_ready[k]), 64'd1);
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (!done[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done[k]) check("done_timeout", 64'(done[k]), 64'd1);
  endtask

  function automatic logic [63:0] outs(input int k);
    return 64'({wr_en[k], rd_en[k], busy[k], done[k], mismatch[k], bad_stage[k], err_addr[k], wr_cnt[k]});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] cnt_model;
    for (int k = 0; k < 2; k++) begin
      cfg_valid[k] = 1'b0; cfg_stage[k] = '0; cfg_addr[k] = '0;
      cfg_data[k]  = '0;   cfg_last[k]  = 1'b0;
      prev_wr[k]   = -1;   done_cnt[k]  = 0;
    end

    // Reset state
    #1;
    check("rst_ready_v", 64'(cfg_ready[0]), 64'd0);
    check("rst_outs_v", outs(0), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready_v", 64'(cfg_ready[0]), 64'd1);
    check("post_rst_ready_w", 64'(cfg_ready[1]), 64'd1);
    check("post_rst_outs_w", outs(1), 64'd0);

    // Basic verified write: accept at t0
    send(0, 8'd1, 8'h05, 48'h0010_0020_0030, 1'b1);
    check("basic_wr_t1", 64'({wr_en[0], ram_addr[0], ram_wdata[0]}), 64'({4'b0010, 8'h05, 48'h0010_0020_0030}));
    check("basic_busy_t1", 64'(busy[0]), 64'd1);
    @(negedge clk);
    check("basic_rd_t2", 64'({wr_en[0], rd_en[0]}), 64'({4'b0000, 4'b0010}));
    @(negedge clk);
    check("basic_nodone_t3", 64'(done[0]), 64'd0);
    @(negedge clk);
    check("basic_nodone_t4", 64'(done[0]), 64'd0);
    @(negedge clk);
    check("basic_done_t5", 64'({done[0], busy[0], mismatch[0], cfg_ready[0]}), 64'({1'b1, 1'b0, 1'b0, 1'b1}));
    check("basic_wr_cnt", 64'(wr_cnt[0]), 64'd1);

    // Read-back mismatch, then a second mismatch that must not overwrite err_addr
    send(0, 8'd2, 8'h7F, 48'hAAAA_BBBB_CCCC, 1'b0);
    wait_ready(0);
    check("mm_flag", 64'(mismatch[0]), 64'd1);
    check("mm_err_addr", 64'(err_addr[0]), 64'({8'd2, 8'h7F}));
    check("mm_busy_mid", 64'(busy[0]), 64'd1);
    send(0, 8'd3, 8'h33, 48'h1234_5678_9ABC, 1'b1);
    wait_done(0);
    check("mm2_flag", 64'(mismatch[0]), 64'd1);
    check("mm2_err_addr", 64'(err_addr[0]), 64'({8'd2, 8'h7F}));
    check("mm2_cnt", 64'(wr_cnt[0]), 64'd3);

    // Out-of-range stage, last record
    send(0, 8'd4, 8'h99, 48'hDEAD_BEEF_0001, 1'b1);
    check("bad_strobes", 64'({wr_en[0], rd_en[0]}), 64'd0);
    check("bad_flags", 64'({bad_stage[0], done[0], cfg_ready[0], busy[0]}), 64'({1'b1, 1'b1, 1'b1, 1'b0}));
    check("bad_err_addr_kept", 64'(err_addr[0]), 64'({8'd2, 8'h7F}));

    // Back-to-back stream on the write-only instance
    stream_mode = 1'b1;
    for (int i = 0; i < 8; i++)
      send(1, 8'(i % 4), 8'(i * 3), {16'(i), 16'(i + 100), 16'(i + 200)}, i == 7);
    wait_done(1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    stream_mode = 1'b0;
    check("stream_done_cnt", 64'(done_cnt[1]), 64'd1);
    check("stream_wr_cnt", 64'(wr_cnt[1]), 64'd8);
    check("stream_busy", 64'(busy[1]), 64'd0);
    check("stream_q_empty", 64'(exp_q1.size()), 64'd0);

    // Reset during WAIT
    send(0, 8'd0, 8'h22, 48'h0101_0202_0303, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait_outs", outs(0), 64'd0);
    check("rst_wait_ready", 64'(cfg_ready[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_wait_ready_rel", 64'(cfg_ready[0]), 64'd1);
    check("rst_wait_cnt", 64'(wr_cnt[0]), 64'd0);
    send(0, 8'd0, 8'h22, 48'h0404_0505_0606, 1'b1);
    wait_done(0);
    check("reload_status", 64'({mismatch[0], bad_stage[0], err_addr[0]}), 64'd0);
    check("reload_cnt", 64'(wr_cnt[0]), 64'd1);

    // Counter saturation: preload near the top, then keep writing
    @(negedge clk);
    force u_dut_w.r_wr_cnt = 16'hFFFC;
    @(negedge clk);
    release u_dut_w.r_wr_cnt;
    cnt_model = 16'hFFFC;
    check("sat_preload", 64'(wr_cnt[1]), 64'(cnt_model));
    for (int i = 0; i < 5; i++) begin
      send(1, 8'd1, 8'(i), 48'(i), i == 4);
      @(negedge clk);
      cnt_model = (cnt_model == 16'hFFFF) ? 16'hFFFF : cnt_model + 16'd1;
      check($sformatf("sat_cnt%0d", i), 64'(wr_cnt[1]), 64'(cnt_model));
    end

    @(negedge clk); @(negedge clk);
    check("final_q0_empty", 64'(exp_q0.size()), 64'd0);
    check("final_q1_empty", 64'(exp_q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
